mem_burst_write_master: RTL and testbench

//  Parametrised burst write master behind mem_write_ifc-style control/user ports.

---
 rtl/mem_burst_write_master.sv | 182 ++++++++++++++++++
 tb/tb_mem_burst_write_master.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_write_master.sv
// mem_burst_write_master: FIFO-buffered Avalon-MM burst write master; bursts stay inside MAX_BURST-word aligned blocks.
// Latency: the first beat comes at least 2 cycles after go; a burst launches only once all its words are buffered.
// Backpressure: avm_waitrequest stalls a burst with address/burstcount/data held; user_full drops pushes unless a beat pops that cycle.
//
// Ports:
//   clk, rst_n                      single clock, asynchronous active-low reset
//   control_base/length/go/done     transfer request (byte address, byte length, start pulse) and idle flag
//   user_we/data/full               write-data push port into the internal FIFO
//   avm_address/write/writedata     Avalon-MM burst write master
//   avm_burstcount/waitrequest

// Small synchronous FIFO with a registered full flag and an occupancy count.
// Push and pop in the same cycle leave the count unchanged, including when full.
module mbw_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count_nxt;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (!push && pop) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (PW+1)'(DEPTH));
    end
  end

  // Storage is not reset: resetting the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

module mem_burst_write_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_WIDTH-1:0]        control_base,
  input  logic [ADDR_WIDTH-1:0]        control_length,
  input  logic                         control_go,
  output logic                         control_done,
  input  logic                         user_we,
  input  logic [DATA_WIDTH-1:0]        user_data,
  output logic                         user_full,
  output logic [ADDR_WIDTH-1:0]        avm_address,
  output logic                         avm_write,
  output logic [DATA_WIDTH-1:0]        avm_writedata,
  output logic [$clog2(MAX_BURST):0]   avm_burstcount,
  input  logic                         avm_waitrequest
);
  localparam int WSH = $clog2(DATA_WIDTH/8);  // byte-to-word shift
  localparam int BCW = $clog2(MAX_BURST) + 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_BURST} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr;        // next burst start address
  logic [ADDR_WIDTH-1:0] words_left;  // words of the transfer not yet accepted
  logic [BCW-1:0]        beats;       // beats left in the current burst
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH-1:0] room;
  logic [ADDR_WIDTH-1:0] bc_full;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_ready;
  logic                  fifo_push;
  logic                  fire;
  logic                  last_beat;
  logic                  launch;
  logic                  go_ok;

  assign fire      = avm_write && !avm_waitrequest;
  assign last_beat = fire && (beats == BCW'(1));
  // A pop frees a slot in the same cycle, so a push is still taken when full.
  assign fifo_push = user_we && (!user_full || fire);

  mbw_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_dat (user_data),
    .pop      (fire),
    .head_dat (avm_writedata),
    .count    (fifo_count),
    .full     (user_full)
  );

  // Burst size: limited by the words remaining and by the distance to the
  // next MAX_BURST-word aligned boundary.
  always_comb begin
    word_idx   = addr >> WSH;
    room       = ADDR_WIDTH'(MAX_BURST) - (word_idx & ADDR_WIDTH'(MAX_BURST - 1));
    bc_full    = (words_left < room) ? words_left : room;
    fifo_ready = (ADDR_WIDTH'(fifo_count) >= bc_full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (control_go && (control_length != '0)) state_nxt = S_ARM;
      S_ARM:   if (fifo_ready) state_nxt = S_BURST;
      S_BURST: if (last_beat) state_nxt = (words_left == ADDR_WIDTH'(1)) ? S_IDLE : S_ARM;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    control_done = (state == S_IDLE);
    avm_write    = (state == S_BURST);
    launch       = (state == S_ARM) && fifo_ready;
    go_ok        = (state == S_IDLE) && control_go && (control_length != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr           <= '0;
      words_left     <= '0;
      beats          <= '0;
      avm_address    <= '0;
      avm_burstcount <= '0;
    end else begin
      if (go_ok) begin
        addr       <= control_base;
        words_left <= control_length >> WSH;
      end
      if (launch) begin
        avm_address    <= addr;
        avm_burstcount <= bc_full[BCW-1:0];
        beats          <= bc_full[BCW-1:0];
      end
      if (fire) begin
        beats      <= beats - 1'b1;
        words_left <= words_left - 1'b1;
        if (last_beat) addr <= addr + (ADDR_WIDTH'(avm_burstcount) << WSH);
      end
    end
  end
endmodule

// File: tb/tb_mem_burst_write_master.sv
module tb_mem_burst_write_master;
  localparam int FD = 32;
  localparam int MB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] control_base = '0;
  logic [31:0] control_length = '0;
  logic        control_go = 1'b0;
  logic        control_done;
  logic        user_we = 1'b0;
  logic [31:0] user_data = '0;
  logic        user_full;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_burstcount;
  logic        avm_waitrequest = 1'b0;

  mem_burst_write_master #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .FIFO_DEPTH (FD),
    .MAX_BURST  (MB)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .control_base    (control_base),
    .control_length  (control_length),
    .control_go      (control_go),
    .control_done    (control_done),
    .user_we         (user_we),
    .user_data       (user_data),
    .user_full       (user_full),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_burstcount  (avm_burstcount),
    .avm_waitrequest (avm_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          bc;
    bit          last;
  } beat_t;

  beat_t       exp_q[$];    // expected beats of the pending transfer
  logic [31:0] data_q[$];   // reference FIFO contents
  bit          exp_done = 1'b1;
  int          checks = 0;
  int          errors = 0;
  int          beats_total = 0;
  int          go_age = 100;
  bit          must_write = 1'b0;
  bit          stall_prev = 1'b0;
  bit          rnd_wait = 1'b0;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_bc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference burst plan: split the transfer at MAX_BURST-word aligned boundaries.
  task automatic plan(input logic [31:0] base, input logic [31:0] len);
    logic [31:0] a;
    int words;
    a = base;
    words = int'(len / 4);
    while (words > 0) begin
      int room;
      int bc;
      room = MB - int'((a / 4) % MB);
      bc = MB;
      if (words < bc) bc = words;
      if (room < bc) bc = room;
      for (int i = 0; i < bc; i++) exp_q.push_back('{a, bc, (i == bc - 1)});
      a = a + 32'(bc * 4);
      words -= bc;
    end
  endtask

  // Random slave stall, driven away from the clock edge.
  always @(posedge clk) begin
    #1;
    avm_waitrequest = rnd_wait ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Monitor / scoreboard: samples on the falling edge, i.e. what the next
  // rising edge will register.
  always @(negedge clk) begin
    bit          fire;
    bit          acc_push;
    bit          done_now;
    beat_t       b;
    logic [31:0] d;
    if (!rst_n) begin
      exp_q.delete();
      data_q.delete();
      exp_done   = 1'b1;
      must_write = 1'b0;
      stall_prev = 1'b0;
      go_age     = 100;
    end else begin
      done_now = exp_done;
      check("user_full", user_full, data_q.size() == FD);
      check("control_done", control_done, exp_done);
      check("write_while_idle", avm_write & exp_done, 0);
      if (go_age == 0) check("go_latency", avm_write, 0);
      if (go_age < 100) go_age++;
      if (must_write) check("mid_burst_gap", avm_write, 1);
      if (stall_prev) begin
        check("stall_write", avm_write, 1);
        check("stall_addr", avm_address, st_addr);
        check("stall_bc", avm_burstcount, st_bc);
        check("stall_data", avm_writedata, st_data);
      end
      fire       = avm_write && !avm_waitrequest;
      acc_push   = user_we && ((data_q.size() < FD) || fire);
      stall_prev = avm_write && avm_waitrequest;
      st_addr    = avm_address;
      st_bc      = avm_burstcount;
      st_data    = avm_writedata;
      must_write = 1'b0;
      if (fire) begin
        beats_total++;
        if (exp_q.size() == 0 || data_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got addr 0x%0h with nothing expected", avm_address);
        end else begin
          b = exp_q.pop_front();
          d = data_q.pop_front();
          check("beat_addr", avm_address, b.addr);
          check("beat_bc", avm_burstcount, 64'(b.bc));
          check("beat_data", avm_writedata, d);
          must_write = !b.last;
          if (exp_q.size() == 0) exp_done = 1'b1;
        end
      end
      if (acc_push) data_q.push_back(user_data);
      if (control_go && done_now && control_length != 0) begin
        plan(control_base, control_length);
        exp_done = 1'b0;
        go_age   = 0;
      end
    end
  end

  task automatic push_words(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      user_we   = 1'b1;
      user_data = $urandom;
      if (max_gap > 0) begin
        int g;
        g = $urandom_range(0, max_gap);
        for (int j = 0; j < g; j++) begin
          @(posedge clk); #1;
          user_we = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    user_we = 1'b0;
  endtask

  task automatic do_go(input logic [31:0] base, input logic [31:0] len);
    @(posedge clk); #1;
    control_base   = base;
    control_length = len;
    control_go     = 1'b1;
    @(posedge clk); #1;
    control_go = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!exp_done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!exp_done) begin
      errors++;
      $display("FAIL timeout: transfer still pending after %0d cycles", budget);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int mark;
    int n;

    // Reset values
    #12;
    check("rst_write", avm_write, 0);
    check("rst_done", control_done, 1);
    check("rst_full", user_full, 0);
    check("rst_addr", avm_address, 0);
    check("rst_bc", avm_burstcount, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Prefilled single burst
    push_words(8, 0);
    do_go(32'h100, 32);
    wait_idle(200);

    // Same with random stalls; exactly 8 beats
    mark = beats_total;
    push_words(8, 0);
    rnd_wait = 1'b1;
    do_go(32'h140, 32);
    wait_idle(500);
    rnd_wait = 1'b0;
    check("stall_beat_count", 64'(beats_total - mark), 8);

    // Unaligned start, streamed data: (0x118,2) then (0x120,8)
    do_go(32'h118, 40);
    push_words(10, 2);
    wait_idle(300);

    // FIFO full: 33rd push dropped, push+pop while full keeps it full
    push_words(33, 0);
    check("full_after_33", user_full, 1);
    @(posedge clk); #1;
    user_we = 1'b1;
    user_data = $urandom;
    control_base = 32'h0;
    control_length = 32;
    control_go = 1'b1;
    @(posedge clk); #1;
    control_go = 1'b0;
    n = 0;
    while (!exp_done && n < 200) begin
      user_data = $urandom;
      @(posedge clk); #1;
      n++;
    end
    user_we = 1'b0;
    check("pushpop_done", exp_done, 1);
    check("full_after_pushpop", user_full, 1);
    do_go(32'h1000, 128);
    wait_idle(400);
    check("drained_not_full", user_full, 0);

    // Zero length go, then a go while busy is ignored
    do_go(32'h500, 0);
    repeat (4) @(posedge clk);
    do_go(32'h200, 32);
    repeat (3) @(posedge clk);
    do_go(32'h400, 64);
    push_words(8, 1);
    wait_idle(300);

    // Address wrap across 2^32
    push_words(4, 0);
    do_go(32'hFFFF_FFF8, 16);
    wait_idle(200);

    // Reset during beat 3 of a burst
    push_words(8, 0);
    do_go(32'h300, 32);
    mark = beats_total;
    n = 0;
    while (!(beats_total == mark + 2 && avm_write) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_beat3", 64'(beats_total - mark), 2);
    rst_n = 1'b0;
    #1;
    check("abort_write", avm_write, 0);
    check("abort_done", control_done, 1);
    check("abort_full", user_full, 0);
    check("abort_bc", avm_burstcount, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_words(16, 0);
    do_go(32'h3F8, 64);
    wait_idle(300);

    // Randomized transfers
    for (int k = 0; k < 10; k++) begin
      logic [31:0] base;
      int nw;
      base = 32'($urandom_range(0, 1023)) << 2;
      nw = $urandom_range(1, 20);
      rnd_wait = (k % 2 == 1);
      do_go(base, 32'(nw * 4));
      push_words(nw, 2);
      wait_idle(1000);
    end
    rnd_wait = 1'b0;

    repeat (3) @(posedge clk);
    check("all_beats_seen", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
